// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer helper for the sync FIFO read-side master.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_SKID_DEPTH = 3;

  // Modulo increment that works for non-power-of-two depths.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_skid_buf.sv
// Circular skid buffer: storage, read/write pointers and occupancy with push/pop/flush.
module sync_fifo_skid_buf
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_SKID_DEPTH,
  localparam int unsigned PW        = $clog2(DEPTH),
  localparam int unsigned OW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [OW-1:0]         occupancy_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [OW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign do_push     = push_i && !flush_i;
  assign do_pop      = pop_i && (count != '0) && !flush_i;
  assign head_o      = mem[rd_ptr];
  assign occupancy_o = count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
      end
      if (do_pop) begin
        rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side master for a sync FIFO: issues reads, absorbs read latency, presents valid/ready.
// Optional flush port enabled by defining SYNC_FIFO_READER_FLUSH_EN.
module sync_fifo_reader
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned SKID_DEPTH = DEF_SKID_DEPTH,
  localparam int unsigned OW        = $clog2(SKID_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
`ifdef SYNC_FIFO_READER_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_read_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OW-1:0]         occupancy_o
);

  localparam logic [OW:0] DEPTH_L = (OW + 1)'(SKID_DEPTH);

  logic        inflight;
  logic        flush;
  logic        transfer;
  logic [OW:0] committed;

`ifdef SYNC_FIFO_READER_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Count the word already requested so the buffer can never be overrun.
  assign committed   = {1'b0, occupancy_o} + {{OW{1'b0}}, inflight};
  assign fifo_read_o = rst_n_i && !fifo_empty_i && !flush && (committed < DEPTH_L);
  assign valid_o     = (occupancy_o != '0);
  assign transfer    = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_read_o;
    end
  end

  sync_fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (inflight),
    .push_data_i (fifo_rd_data_i),
    .pop_i       (transfer),
    .flush_i     (flush),
    .head_o      (data_o),
    .occupancy_o (occupancy_o)
  );

`ifndef SYNTHESIS
  a_no_read_when_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(fifo_read_o && fifo_empty_i));
  a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    occupancy_o <= OW'(SKID_DEPTH));
`endif

endmodule
